seg_scan_capture: RTL
=====================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, giving synchronized-sample dwell cycles before a digit capture (range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port enable  input  4  multiplexed digit anodes, active-low one-hot (0111=digit3 … 1110=digit0).
REQ-005 SHALL have port out  input  7  segment lines, active-low, bit6=a … bit0=g (0000001 = "0").
REQ-006 SHALL have port value  output  16  captured hex digits, digit3 in [15:12] … digit0 in [3:0].
REQ-007 SHALL have port digit_valid  output  4  per-digit flag: last capture of that digit decoded to a legal glyph.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse on each digit0 capture.
REQ-009 SHALL have port value_changed  output  1  one-cycle pulse, coincident with frame_done, when value differs from value at previous frame_done.
REQ-010 SHALL have port decode_err  output  1  sticky flag, set by any illegal glyph capture.

Function
REQ-011 SHALL pass enable and out through a 2-flop synchronizer; all further logic uses synchronized copies.
REQ-012 SHALL run FSM IDLE/SETTLE/HOLD; IDLE when synchronized enable is not one-hot-low.
REQ-013 SHALL reset a 16-bit dwell counter to 0 and enter SETTLE (or IDLE) whenever synchronized {enable,out} differs from previous cycle.
REQ-014 SHALL, in SETTLE, increment the counter each cycle inputs are unchanged; on reaching STABLE_CYCLES-1 capture the digit and move to HOLD.
REQ-015 SHALL capture exactly once per dwell; HOLD persists until inputs change, counter saturates (no wrap).
REQ-016 SHALL decode the 16 glyphs 0-F per the team's hex table (e.g. 0001100=9, 1100000=b, 0111000=F) into the selected nibble and set its digit_valid bit.
REQ-017 SHALL, on an illegal glyph, leave the nibble unchanged, clear its digit_valid bit, set decode_err.
REQ-018 SHALL produce capture latency of exactly 2+STABLE_CYCLES clk edges from a pin change to the value update edge.
REQ-019 SHALL compare against a shadow of value latched at each frame_done to generate value_changed; first frame after reset compares against 0.
REQ-020 SHALL drop an in-progress dwell with no capture if enable becomes non-one-hot or changes before count completes.

Reset
REQ-021 SHALL, on reset low, asynchronously clear synchronizers, counter, FSM (to IDLE), value=0, shadow=0, digit_valid=0, frame_done=0, value_changed=0, decode_err=0.
REQ-022 SHALL clear decode_err only by reset.
REQ-023 SHALL discard any dwell in progress when reset asserts mid-operation; the first capture after release needs a full new dwell.

Configuration
REQ-024 SHALL, with SEG_SCAN_BLANK_EN defined, treat glyph 1111111 as blank: nibble unchanged, digit_valid bit cleared, decode_err not set.
REQ-025 SHALL, without SEG_SCAN_BLANK_EN, treat 1111111 as an illegal glyph per REQ-017.

Verification
REQ-026 SHALL cover: enable=1110, out=0000110 held 20 cycles -> value[3:0]=3, digit_valid[0]=1, frame_done and value_changed pulse once at edge 18.
REQ-027 SHALL cover: digit1=0001000(A), digit0=0000001(0) alternating every 32 cycles -> value=0x00A0, value_changed on first frame only.
REQ-028 SHALL cover: out toggles every 10 cycles with STABLE_CYCLES=16 -> no capture, value unchanged, no pulses.
REQ-029 SHALL cover: enable=1100 held 40 cycles -> IDLE, no capture, outputs unchanged.
REQ-030 SHALL cover: enable=1110, out=1111111 held 20 cycles -> with SEG_SCAN_BLANK_EN decode_err=0, without decode_err=1; digit_valid[0]=0 in both.
REQ-031 SHALL cover: reset low at dwell cycle 10 then released -> all outputs 0, capture at edge 18 after release.

Source files
------------

// File: rtl/seg_scan_capture.sv
// ---------------------------------------------------------------------------
// seg_scan_capture
//
// Watches a multiplexed, active-low 7-segment display bus (anodes + segment
// lines) and recovers the four hex digits being shown. Each digit is only
// captured once the bus has been quiet for STABLE_CYCLES synchronized
// samples, so ghosting during anode switching is filtered out.
//
// Parameters:
//   STABLE_CYCLES  dwell length in synchronized samples before a capture
//                  (2..65535). Pin change to value update is 2+STABLE_CYCLES
//                  clock edges.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous reset, active low
//   enable[3:0]    digit anodes, active-low one-hot (1110 = digit0)
//   out[6:0]       segments, active-low, bit6 = a ... bit0 = g
//   value[15:0]    captured digits, digit3 in [15:12] ... digit0 in [3:0]
//   digit_valid    per digit: last capture decoded to a legal glyph
//   frame_done     one-cycle pulse on every digit0 capture
//   value_changed  one-cycle pulse with frame_done when value differs from
//                  the value seen at the previous frame_done
//   decode_err     sticky, set by any illegal glyph capture
//
// Build option:
//   SEG_SCAN_BLANK_EN  when defined, the all-off glyph 1111111 is treated as
//                      a blank digit (no decode error) instead of illegal.
// ---------------------------------------------------------------------------
module seg_scan_capture #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  enable,
  input  logic [6:0]  out,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        value_changed,
  output logic        decode_err
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // Capture fires on the edge where the counter steps to STABLE_CYCLES-1.
  localparam logic [15:0] CAPTURE_AT = 16'(STABLE_CYCLES - 2);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  logic [3:0]  en_meta, en_sync, en_prev;
  logic [6:0]  seg_meta, seg_sync, seg_prev;
  logic        bus_changed;
  logic        one_hot;
  logic [1:0]  sel;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        capture;

  logic        glyph_legal;
  logic        glyph_blank;
  logic [3:0]  glyph_nibble;

  logic [15:0] value_next;
  logic [3:0]  valid_next;
  logic [15:0] shadow;

  // Two-flop synchronizer for the asynchronous display bus, plus one more
  // stage holding last cycle's synchronized sample for change detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_meta  <= '0;
      en_sync  <= '0;
      en_prev  <= '0;
      seg_meta <= '0;
      seg_sync <= '0;
      seg_prev <= '0;
    end else begin
      en_meta  <= enable;
      en_sync  <= en_meta;
      en_prev  <= en_sync;
      seg_meta <= out;
      seg_sync <= seg_meta;
      seg_prev <= seg_sync;
    end
  end

  assign bus_changed = ({en_sync, seg_sync} != {en_prev, seg_prev});

  // Map the active-low one-hot anode pattern to a digit index.
  always_comb begin
    one_hot = 1'b1;
    sel     = 2'd0;
    case (en_sync)
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: one_hot = 1'b0;
    endcase
  end

  // Glyph decode, active-low segments a..g in bits 6..0.
  always_comb begin
    glyph_legal  = 1'b1;
    glyph_nibble = 4'h0;
    case (seg_sync)
      7'b0000001: glyph_nibble = 4'h0;
      7'b1001111: glyph_nibble = 4'h1;
      7'b0010010: glyph_nibble = 4'h2;
      7'b0000110: glyph_nibble = 4'h3;
      7'b1001100: glyph_nibble = 4'h4;
      7'b0100100: glyph_nibble = 4'h5;
      7'b0100000: glyph_nibble = 4'h6;
      7'b0001111: glyph_nibble = 4'h7;
      7'b0000000: glyph_nibble = 4'h8;
      7'b0001100: glyph_nibble = 4'h9;
      7'b0001000: glyph_nibble = 4'hA;
      7'b1100000: glyph_nibble = 4'hB;
      7'b0110001: glyph_nibble = 4'hC;
      7'b1000010: glyph_nibble = 4'hD;
      7'b0110000: glyph_nibble = 4'hE;
      7'b0111000: glyph_nibble = 4'hF;
      default:    glyph_legal  = 1'b0;
    endcase
`ifdef SEG_SCAN_BLANK_EN
    glyph_blank = (seg_sync == 7'b1111111);
`else
    glyph_blank = 1'b0;
`endif
  end

  // FSM state and dwell counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any bus change restarts the dwell (or parks in IDLE when no single digit
  // is selected). HOLD keeps counting up to saturation so a long-held digit
  // can never wrap around into a second capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (bus_changed) begin
      cnt_d   = '0;
      state_d = one_hot ? SETTLE : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
        end
        SETTLE: begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == CAPTURE_AT) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 16'd1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Next value / valid vector after this cycle's capture (if any).
  always_comb begin
    value_next = value;
    valid_next = digit_valid;
    if (capture) begin
      valid_next[sel] = glyph_legal;
      if (glyph_legal) begin
        case (sel)
          2'd0:    value_next[3:0]   = glyph_nibble;
          2'd1:    value_next[7:4]   = glyph_nibble;
          2'd2:    value_next[11:8]  = glyph_nibble;
          default: value_next[15:12] = glyph_nibble;
        endcase
      end
    end
  end

  // Output registers. The shadow copy is taken at every digit0 capture so
  // value_changed compares whole frames, not individual digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value         <= '0;
      digit_valid   <= '0;
      shadow        <= '0;
      frame_done    <= 1'b0;
      value_changed <= 1'b0;
      decode_err    <= 1'b0;
    end else begin
      value         <= value_next;
      digit_valid   <= valid_next;
      frame_done    <= 1'b0;
      value_changed <= 1'b0;
      if (capture && !glyph_legal && !glyph_blank) decode_err <= 1'b1;
      if (capture && (sel == 2'd0)) begin
        frame_done    <= 1'b1;
        value_changed <= (value_next != shadow);
        shadow        <= value_next;
      end
    end
  end

endmodule
